// File: rtl/glb_iact_bank.sv
// glb_iact_bank: one global-buffer bank holding an input-activation stream.
// A loader writes a stream (write_en pulse, then valid/ready beats ending with
// in_last); the PE array then replays it any number of times via read_en.
// Optional macro GLB_BANK_OVF_TRUNC_EN: when defined, a stream that runs past
// DEPTH is cut off at the last address; otherwise the excess beats are
// accepted and dropped until in_last.
module glb_iact_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              write_done,
    input  logic              read_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              read_done,
    output logic [ADDR_W:0]   length,
    output logic              overflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
`ifdef GLB_BANK_OVF_TRUNC_EN
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic [CNT_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] length_reg;
    logic             overflow_reg;
    logic             out_valid_reg;
    logic             write_done_reg;
    logic             read_done_reg;

    logic              in_beat;
    logic              wr_store;
    logic              wr_trunc;
    logic              wr_end;
    logic              rd_first;
    logic              rd_load;
    logic              rd_end;
    logic              rd_empty;
    logic              rd_is_last;
    logic [ADDR_W-1:0] rd_addr;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_next = state_reg;
        in_beat    = 1'b0;
        wr_store   = 1'b0;
        wr_trunc   = 1'b0;
        wr_end     = 1'b0;
        rd_first   = 1'b0;
        rd_load    = 1'b0;
        rd_end     = 1'b0;
        rd_empty   = 1'b0;
        rd_is_last = (rd_ptr_reg == length_reg - ONE);
        case (state_reg)
            IDLE: begin
                if (write_en)     state_next = WRITE;
                else if (read_en) state_next = READ;
            end
            WRITE: begin
                in_beat  = in_valid;
                // Beats past the last address are acknowledged but not stored
                wr_store = in_valid && (wr_ptr_reg < DEPTH_CNT);
`ifdef GLB_BANK_OVF_TRUNC_EN
                wr_trunc = in_valid && !in_last && (wr_ptr_reg == LAST_ADDR);
`endif
                wr_end   = in_valid && (in_last || wr_trunc);
                if (wr_end) state_next = IDLE;
            end
            READ: begin
                if (!out_valid_reg) begin
                    // Entry cycle: fetch address 0, or finish at once if empty
                    if (length_reg == '0) begin
                        rd_empty   = 1'b1;
                        state_next = HOLD;
                    end else begin
                        rd_first = 1'b1;
                        rd_load  = 1'b1;
                    end
                end else if (out_ready) begin
                    if (rd_is_last) begin
                        rd_end     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        rd_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Wait for the controller to drop read_en so one request = one read
                if (!read_en) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr = rd_first ? '0 : ADDR_W'(rd_ptr_reg + ONE);

    // Write pointer, stored length, overflow flag and write completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            length_reg     <= '0;
            overflow_reg   <= 1'b0;
            write_done_reg <= 1'b0;
        end else begin
            write_done_reg <= 1'b0;
            if (state_reg == IDLE && write_en) begin
                wr_ptr_reg   <= '0;
                length_reg   <= '0;
                overflow_reg <= 1'b0;
            end else if (in_beat) begin
                if (!wr_store || wr_trunc) overflow_reg <= 1'b1;
                if (wr_store)              wr_ptr_reg   <= wr_ptr_reg + ONE;
                if (wr_end) begin
                    write_done_reg <= 1'b1;
                    length_reg     <= wr_store ? wr_ptr_reg + ONE : DEPTH_CNT;
                end
            end
        end
    end

    // Read pointer, output-valid and read completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            read_done_reg <= 1'b0;
        end else begin
            read_done_reg <= rd_end | rd_empty;
            if ((state_reg == IDLE && !write_en && read_en) || rd_first) begin
                rd_ptr_reg <= '0;
            end else if (rd_load) begin
                rd_ptr_reg <= rd_ptr_reg + ONE;
            end
            if (rd_first)    out_valid_reg <= 1'b1;
            else if (rd_end) out_valid_reg <= 1'b0;
        end
    end

    // Storage array: write port from the loader, registered read port that
    // only advances on a fetch so a stalled beat keeps its data
    always_ff @(posedge clock) begin
        if (wr_store) mem[wr_ptr_reg[ADDR_W-1:0]] <= in_data;
        if (rd_load)  ram_q <= mem[rd_addr];
    end

    assign in_ready   = (state_reg == WRITE);
    assign out_valid  = out_valid_reg;
    assign out_data   = out_valid_reg ? ram_q : '0;
    assign out_last   = out_valid_reg && rd_is_last;
    assign write_done = write_done_reg;
    assign read_done  = read_done_reg;
    assign length     = length_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_glb_iact_bank.sv
// tb_glb_iact_bank: directed plus randomized bench for glb_iact_bank (DEPTH=8).
// The reference model is a queue of the words the bank should hold.
module tb_glb_iact_bank;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              reset;
    logic              write_en;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              write_done;
    logic              read_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              read_done;
    logic [ADDR_W:0]   length;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] stim_q[$];
    int                model_len;
    logic              model_ovf;

    glb_iact_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .write_en(write_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .write_done(write_done),
        .read_en(read_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .read_done(read_done),
        .length(length), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   0);
        check({tag, "_out_valid"},  32'(out_valid),  0);
        check({tag, "_out_data"},   32'(out_data),   0);
        check({tag, "_out_last"},   32'(out_last),   0);
        check({tag, "_write_done"}, 32'(write_done), 0);
        check({tag, "_read_done"},  32'(read_done),  0);
        check({tag, "_length"},     32'(length),     0);
        check({tag, "_overflow"},   32'(overflow),   0);
    endtask

    // Writes stim_q as one stream; optionally raises read_en alongside write_en
    task automatic write_stream(input bit also_read);
        int n;
        int sent;
        n = stim_q.size();
`ifdef GLB_BANK_OVF_TRUNC_EN
        sent = (n > DEPTH) ? DEPTH : n;
`else
        sent = n;
`endif
        step();
        write_en = 1'b1;
        read_en  = also_read;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        for (int i = 0; i < sent; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clock);
                check("wr_gap_ready", 32'(in_ready), 1);
                step();
            end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = (i == n - 1);
            @(negedge clock);
            check("wr_ready", 32'(in_ready), 1);
            check("wr_done_early", 32'(write_done), 0);
            check("wr_no_out_valid", 32'(out_valid), 0);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_len = (n > DEPTH) ? DEPTH : n;
        model_ovf = (n > DEPTH);
        model_q   = {};
        for (int i = 0; i < model_len; i++) model_q.push_back(stim_q[i]);
        check("wr_done_pulse", 32'(write_done), 1);
        check("wr_idle_ready", 32'(in_ready), 0);
        check("wr_length", 32'(length), 32'(model_len));
        check("wr_overflow", 32'(overflow), 32'(model_ovf));
        step();
        check("wr_done_once", 32'(write_done), 0);
        $display("write n=%0d length=%0d overflow=%0d", n, length, overflow);
    endtask

    // Reads the bank with read_en held; mode 0 ready always, 1 pattern 1,0,0,1, 2 random
    task automatic do_read(input int mode);
        int idx;
        int cyc;
        step();
        read_en   = 1'b1;
        out_ready = 1'b0;
        step();
        check("rd_entry_valid", 32'(out_valid), 0);
        check("rd_entry_done", 32'(read_done), 0);
        if (model_len == 0) begin
            step();
            check("rd_empty_done", 32'(read_done), 1);
            check("rd_empty_valid", 32'(out_valid), 0);
            idx = 0;
        end else begin
            step();
            idx = 0;
            cyc = 0;
            while (idx < model_len && cyc < 200) begin
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                @(negedge clock);
                check("rd_valid", 32'(out_valid), 1);
                check("rd_data", 32'(out_data), 32'(model_q[idx]));
                check("rd_last", 32'(out_last), 32'(idx == model_len - 1));
                check("rd_done_early", 32'(read_done), 0);
                if (out_ready) idx++;
                step();
                cyc++;
            end
            check("rd_beats", 32'(idx), 32'(model_len));
            check("rd_done_pulse", 32'(read_done), 1);
            check("rd_valid_drop", 32'(out_valid), 0);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rd_no_reread_valid", 32'(out_valid), 0);
            check("rd_done_once", 32'(read_done), 0);
        end
        read_en = 1'b0;
        step();
        $display("read mode=%0d beats=%0d length=%0d", mode, idx, model_len);
    endtask

    task automatic random_stim(input int n);
        stim_q = {};
        for (int i = 0; i < n; i++) stim_q.push_back(DATA_W'($urandom));
    endtask

    initial begin
        reset     = 1'b1;
        write_en  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        read_en   = 1'b0;
        out_ready = 1'b0;
        model_q   = {};
        model_len = 0;
        model_ovf = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Read with nothing written
        do_read(0);

        // Five-word stream, then replays with different ready patterns
        stim_q = {16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
        write_stream(1'b0);
        do_read(0);
        do_read(0);
        do_read(1);

        // write_en and read_en together: write wins
        random_stim(3);
        write_stream(1'b1);
        do_read(2);

        // Exactly DEPTH words: no overflow
        random_stim(DEPTH);
        write_stream(1'b0);
        do_read(0);

        // DEPTH+2 words: overflow, length capped
        random_stim(DEPTH + 2);
        write_stream(1'b0);
        do_read(1);

        // Randomized streams and read patterns
        for (int r = 0; r < 6; r++) begin
            random_stim($urandom_range(1, DEPTH + 3));
            write_stream(1'b0);
            do_read($urandom_range(0, 2));
        end

        // Reset in the middle of a stalled read
        stim_q = {16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
        write_stream(1'b0);
        step();
        read_en   = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        check("midrd_valid", 32'(out_valid), 1);
        reset = 1'b1;
        step();
        check_all_zero("midrd_reset");
        reset   = 1'b0;
        read_en = 1'b0;
        model_q   = {};
        model_len = 0;
        model_ovf = 1'b0;
        step();
        do_read(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glb_iact_bank.md
GLB_IACT_BANK -- requirements
Module: glb_iact_bank

Interface
REQ-001 Parameter DATA_W, default 16: width of one stored iact data/address word.
REQ-002 Parameter DEPTH, default 64: number of storage words; ADDR_W = clog2(DEPTH).
REQ-003 Port clock  in  1  single clock, all logic rising-edge.
REQ-004 Port reset  in  1  synchronous, active-high.
REQ-005 Port write_en  in  1  one-cycle start-of-write pulse from the cluster group controller.
REQ-006 Port in_valid / in_ready  in / out  1 / 1  write stream handshake from the loader.
REQ-007 Port in_data / in_last  in / in  DATA_W / 1  write beat and end-of-stream marker.
REQ-008 Port write_done  out  1  one-cycle pulse, write stream complete.
REQ-009 Port read_en  in  1  level request from the controller; held until read_done is seen.
REQ-010 Port out_valid / out_ready  out / in  1 / 1  read stream handshake to the PE array.
REQ-011 Port out_data / out_last  out / out  DATA_W / 1  read beat and final-beat marker.
REQ-012 Port read_done  out  1  one-cycle pulse, read stream complete.
REQ-013 Port length  out  ADDR_W+1  number of valid stored words.
REQ-014 Port overflow  out  1  sticky flag: write stream exceeded DEPTH.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE, READ and HOLD.
REQ-016 In IDLE, write_en=1 SHALL select WRITE and clear the write pointer, length and overflow; write_en has priority over read_en in the same cycle.
REQ-017 In IDLE, read_en=1 with write_en=0 SHALL select READ and clear the read pointer.
REQ-018 write_en outside IDLE and read_en outside IDLE/HOLD SHALL be ignored.
REQ-019 In WRITE, in_ready SHALL be 1. Each in_valid&in_ready beat SHALL store in_data at the write pointer and then increment the pointer.
REQ-020 A beat with in_last=1 SHALL set length to the stored-beat count, pulse write_done in the next cycle, and return to IDLE.
REQ-021 Storage SHALL be synchronous-read. The READ entry cycle SHALL present address 0, and out_valid SHALL rise one cycle later (latency 1).
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold.
REQ-023 On each out_valid&out_ready, the bank SHALL present the next address. Back-to-back beats SHALL run with no bubble.
REQ-024 out_last SHALL be 1 on the beat whose address is length-1.
REQ-025 When the last beat is accepted, the bank SHALL pulse read_done in the next cycle, drop out_valid, and enter HOLD.
REQ-026 If length=0 on entering READ, out_valid SHALL stay 0 and read_done SHALL pulse in the next cycle, followed by HOLD.
REQ-027 HOLD SHALL return to IDLE when read_en=0; a read_en still high after read_done SHALL NOT start a second read.
REQ-028 length SHALL be unchanged by reads, so repeated reads replay the same data.
REQ-029 Outside WRITE, in_ready SHALL be 0; outside READ, out_valid SHALL be 0.

Reset
REQ-030 Reset SHALL force IDLE and set pointers, length and overflow to 0.
REQ-031 Reset SHALL set all outputs to 0, including a reset that arrives mid-stream.
REQ-032 Storage contents need not be reset.

Configuration
REQ-033 Macro GLB_BANK_OVF_TRUNC_EN selects the overflow behaviour.
REQ-034 With GLB_BANK_OVF_TRUNC_EN defined, a beat accepted at address DEPTH-1 without in_last SHALL:
- set overflow;
- set length=DEPTH;
- pulse write_done;
- return to IDLE.
REQ-035 With GLB_BANK_OVF_TRUNC_EN undefined, beats beyond DEPTH SHALL be accepted and discarded with in_ready=1 and overflow set, until in_last. length then equals DEPTH.
REQ-036 In both cases, a stream of exactly DEPTH beats with in_last on beat DEPTH SHALL NOT set overflow.

Verification
REQ-037 write_en pulse, then 5 beats 0x11..0x15 with in_last on 0x15 -> length=5, write_done pulses the cycle after 0x15, overflow=0.
REQ-038 read_en held with out_ready=1 -> out_valid rises 1 cycle after READ entry, out_data 0x11..0x15 on consecutive cycles, out_last on 0x15, read_done pulses once, no re-read while read_en is still high.
REQ-039 Same read with out_ready toggling 1,0,0,1 -> each beat holds while out_ready=0, data order unchanged, exactly 5 handshakes.
REQ-040 Read after reset with no write -> read_done pulses 1 cycle after READ entry, out_valid never 1.
REQ-041 DEPTH=4, 6-beat stream -> with the macro: done after beat 4, overflow=1, length=4; without the macro: in_ready stays 1 for 6 beats, done after beat 6, length=4, overflow=1.
REQ-042 write_en and read_en asserted in the same IDLE cycle -> WRITE entered; reset asserted mid-read -> all outputs 0 the next cycle, and length=0.
